// File: rtl/pulsar_seq.sv
// pulsar_seq: table-driven multi-channel pulse sequencer.
//
// A DEPTH-entry table of {dur, pat} records is written through the wr_* port
// and read combinationally. After a start pulse the block walks entries
// 0..len-1, driving pat on drv for dur+1 cycles each, then either wraps to
// entry 0 (loop=1) or returns to IDLE with a one-cycle done pulse (loop=0).
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   wr_en/wr_addr/      table write strobe, address, duration and pattern
//   wr_dur/wr_pat
//   len                 active entry count (0..DEPTH)
//   loop                1 = wrap after the last entry, 0 = one-shot
//   start, stop         single-cycle start / abort pulses (stop wins)
//   drv                 registered channel drive
//   busy                high while in RUN
//   done                one-cycle pulse at one-shot completion
//   ptr                 index of the current entry
//
// Optional feature: define PULSAR_SEQ_RETRIG_EN to compile in a free-running
// PW-bit counter whose MSB rising edge acts as an extra start every 2^PW cycles.
module pulsar_seq #(
    parameter int CH    = 4,
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int TW    = 32,
    parameter int PW    = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [TW-1:0] wr_dur,
    input  logic [CH-1:0] wr_pat,
    input  logic [AW:0]   len,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    output logic [CH-1:0] drv,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ptr
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [TW-1:0] dur_mem [DEPTH];
    logic [CH-1:0] pat_mem [DEPTH];

    logic [0:0]    state_r, state_s;
    logic [AW-1:0] ptr_r, ptr_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [CH-1:0] drv_r, drv_s;
    logic          done_r, done_s;

    logic          start_any_s;
    logic [AW:0]   ptr_inc_s;
    logic          is_last_s;
    logic          len_nz_s;

`ifdef PULSAR_SEQ_RETRIG_EN
    logic [PW-1:0] retrig_cnt_r;
    logic          retrig_msb_d_r;

    // Free-running retrigger counter and delayed copy of its MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retrig_cnt_r   <= {PW{1'b0}};
            retrig_msb_d_r <= 1'b0;
        end else begin
            retrig_cnt_r   <= retrig_cnt_r + {{(PW-1){1'b0}}, 1'b1};
            retrig_msb_d_r <= retrig_cnt_r[PW-1];
        end
    end

    assign start_any_s = start | (retrig_cnt_r[PW-1] & ~retrig_msb_d_r);
`else
    assign start_any_s = start;
`endif

    // Table storage; not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            dur_mem[wr_addr] <= wr_dur;
            pat_mem[wr_addr] <= wr_pat;
        end
    end

    assign len_nz_s  = (len != {(AW+1){1'b0}});
    assign ptr_inc_s = {1'b0, ptr_r} + {{AW{1'b0}}, 1'b1};
    // ptr >= len-1 written without subtraction so len shrunk to 0 mid-run
    // also counts as "last entry".
    assign is_last_s = (ptr_inc_s >= len);

    // Next-state decision: stop, (re)start, countdown, advance, wrap or finish.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        timer_s = timer_r;
        drv_s   = drv_r;
        done_s  = 1'b0;
        if (stop) begin
            state_s = IDLE;
            drv_s   = {CH{1'b0}};
            timer_s = {TW{1'b0}};
        end else if (start_any_s && len_nz_s) begin
            state_s = RUN;
            ptr_s   = {AW{1'b0}};
            timer_s = dur_mem[{AW{1'b0}}];
            drv_s   = pat_mem[{AW{1'b0}}];
        end else if (state_r == RUN) begin
            if (timer_r != {TW{1'b0}}) begin
                timer_s = timer_r - {{(TW-1){1'b0}}, 1'b1};
            end else if (!is_last_s) begin
                ptr_s   = ptr_inc_s[AW-1:0];
                timer_s = dur_mem[ptr_inc_s[AW-1:0]];
                drv_s   = pat_mem[ptr_inc_s[AW-1:0]];
            end else if (loop) begin
                ptr_s   = {AW{1'b0}};
                timer_s = dur_mem[{AW{1'b0}}];
                drv_s   = pat_mem[{AW{1'b0}}];
            end else begin
                state_s = IDLE;
                drv_s   = {CH{1'b0}};
                done_s  = 1'b1;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= {AW{1'b0}};
            timer_r <= {TW{1'b0}};
            drv_r   <= {CH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            timer_r <= timer_s;
            drv_r   <= drv_s;
            done_r  <= done_s;
        end
    end

    assign drv  = drv_r;
    assign busy = (state_r == RUN);
    assign done = done_r;
    assign ptr  = ptr_r;

endmodule

// File: tb/tb_pulsar_seq.sv
module tb_pulsar_seq;

    localparam int CH = 4;
    localparam int AW = 8;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [TW-1:0] wr_dur = '0;
    logic [CH-1:0] wr_pat = '0;
    logic [AW:0]   len = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CH-1:0] drv;
    logic          busy;
    logic          done;
    logic [AW-1:0] ptr;

    int n_chk = 0;
    int n_fail = 0;

    pulsar_seq #(.CH(CH), .DEPTH(256), .AW(AW), .TW(TW), .PW(6)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_dur(wr_dur), .wr_pat(wr_pat), .len(len), .loop(loop),
        .start(start), .stop(stop), .drv(drv), .busy(busy),
        .done(done), .ptr(ptr)
    );

    always #5 clk = ~clk;

    // Reference copy of the first few table entries.
    int m_dur [4];
    int m_pat [4];

    typedef struct {
        logic       start;
        logic       stop;
        logic [3:0] exp_drv;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input int d, input int p);
        wr_en = 1'b1;
        wr_addr = a[AW-1:0];
        wr_dur = d;
        wr_pat = p[CH-1:0];
        step();
        wr_en = 1'b0;
        if (a < 4) begin
            m_dur[a] = d;
            m_pat[a] = p;
        end
    endtask

    // REQ-021 scenario: 3x 0x1, 1x 0x2, 5x 0x4, then idle with a done pulse.
    task automatic apply_vectors(input string tag);
        len = 9'd3;
        loop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start;
            stop = vecs[i].stop;
            step();
            start = 1'b0;
            stop = 1'b0;
            chk($sformatf("%s_drv[%0d]", tag, i), int'(drv), int'(vecs[i].exp_drv));
            chk($sformatf("%s_busy[%0d]", tag, i), int'(busy), int'(vecs[i].exp_busy));
            chk($sformatf("%s_done[%0d]", tag, i), int'(done), int'(vecs[i].exp_done));
        end
    endtask

    // Behavioural model: a run is the flattened list of per-cycle patterns.
    int q [$];
    logic [3:0] m_drv;
    logic m_busy, m_done;

    function automatic void fill(input int n);
        q.delete();
        for (int e = 0; e < n; e++)
            for (int k = 0; k <= m_dur[e]; k++)
                q.push_back(m_pat[e]);
    endfunction

    function automatic void model_edge();
        if (stop) begin
            m_busy = 1'b0; m_drv = 4'd0; m_done = 1'b0; q.delete();
        end else if (start && len != 0) begin
            fill(int'(len));
            m_drv = q.pop_front();
            m_busy = 1'b1; m_done = 1'b0;
        end else if (m_busy) begin
            m_done = 1'b0;
            if (q.size() == 0 && loop) fill(int'(len));
            if (q.size() != 0) m_drv = q.pop_front();
            else begin
                m_busy = 1'b0; m_drv = 4'd0; m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
    endfunction

    initial begin
        int exp_loop [9];
        int base;
        int found;
        exp_loop = '{1, 1, 1, 2, 4, 4, 4, 4, 4};
        for (int i = 0; i < 12; i++) vecs[i] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[0] = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 4'h1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 4'h1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 4'h2, 1'b1, 1'b0};
        for (int i = 4; i < 9; i++) vecs[i] = '{1'b0, 1'b0, 4'h4, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0};

        #12;
        chk("reset_drv", int'(drv), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ptr", int'(ptr), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

`ifdef PULSAR_SEQ_RETRIG_EN
        // Retrigger: len=1, entry 0 = {3, 0xF}; 4 cycles of 0xF every 64.
        write_entry(0, 3, 15);
        len = 9'd1;
        loop = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (busy) found = 1;
        end
        chk("retrig_first_seen", found, 1);
        for (int k = 1; k < 140; k++) begin
            step();
            chk($sformatf("retrig_drv[%0d]", k), int'(drv), ((k % 64) < 4) ? 15 : 0);
        end
`else
        // No activity without the start port.
        write_entry(0, 3, 15);
        len = 9'd1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy || drv != 0) break;
        end
        chk("noretrig_busy", int'(busy), 0);
        chk("noretrig_drv", int'(drv), 0);

        write_entry(0, 2, 1);
        write_entry(1, 0, 2);
        write_entry(2, 4, 4);
        apply_vectors("oneshot");

        // Looping: 9-cycle period, never done.
        loop = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 27; k++) begin
            if (k > 0) step();
            chk($sformatf("loop_drv[%0d]", k), int'(drv), exp_loop[k % 9]);
            chk($sformatf("loop_done[%0d]", k), int'(done), 0);
        end

        // Start and stop together while running: stop wins.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("stopwin_busy", int'(busy), 0);
        chk("stopwin_drv", int'(drv), 0);
        chk("stopwin_done", int'(done), 0);
        step();
        chk("stopwin_done2", int'(done), 0);
        loop = 1'b0;

        // len=0 start is ignored.
        len = 9'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("len0_busy", int'(busy), 0);
        chk("len0_drv", int'(drv), 0);
        step();
        chk("len0_done", int'(done), 0);

        // Write to the running entry does not disturb it; next load sees it.
        len = 9'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("wrrun_pre", int'(drv), 4);
        write_entry(2, 4, 8);
        chk("wrrun_hold0", int'(drv), 4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("wrrun_hold%0d", i + 1), int'(drv), 4);
        end
        step();
        chk("wrrun_done", int'(done), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("wrrun_new", int'(drv), 8);
        stop = 1'b1;
        step();
        stop = 1'b0;
        write_entry(2, 4, 4);

        // len shrunk mid-run: current entry becomes the last one.
        start = 1'b1;
        step();
        start = 1'b0;
        len = 9'd1;
        step();
        step();
        chk("lenshrink_hold", int'(drv), 1);
        step();
        chk("lenshrink_done", int'(done), 1);
        chk("lenshrink_busy", int'(busy), 0);
        len = 9'd3;

        // Async reset mid-entry (entry 2, timer=3).
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("rst_pre_drv", int'(drv), 4);
        rst = 1'b1;
        #1;
        chk("rst_async_drv", int'(drv), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_done", int'(done), 0);
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        apply_vectors("after_rst");

        // Randomized run against the behavioural model.
        m_busy = 1'b0; m_drv = 4'd0; m_done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!m_busy && $urandom_range(0, 3) == 0) begin
                len = 9'($urandom_range(0, 4));
                loop = 1'($urandom_range(0, 1));
                write_entry($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
                m_done = 1'b0;
            end
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 24) == 0);
            step();
            model_edge();
            start = 1'b0;
            stop = 1'b0;
            chk($sformatf("rand_drv[%0d]", i), int'(drv), int'(m_drv));
            chk($sformatf("rand_busy[%0d]", i), int'(busy), int'(m_busy));
            chk($sformatf("rand_done[%0d]", i), int'(done), int'(m_done));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pulsar_seq.md
PULSAR_SEQ -- requirements
Module: pulsar_seq

Interface
REQ-001 The block SHALL have these parameters:
- CH, default 4, number of drive channels.
- DEPTH, default 256, number of sequence table entries (power of 2).
- AW, default 8, table address width, equal to log2(DEPTH).
- TW, default 32, duration field width.
- PW, default 24, width of the internal retrigger counter.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_dur  in  TW  duration field to write.
- wr_pat  in  CH  channel pattern field to write.
- len  in  AW+1  active entry count, 0..DEPTH.
- loop  in  1  1 = wrap to entry 0 after the last entry; 0 = one-shot.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle abort pulse.
- drv  out  CH  registered channel drive.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at one-shot completion.
- ptr  out  AW  index of the current entry.

Function
REQ-003 Table entries SHALL be {dur, pat}, written on a clk edge when wr_en=1, with asynchronous (combinational) read.
REQ-004 The state machine SHALL have states IDLE and RUN.
REQ-005 A start accepted in IDLE or RUN with len!=0 SHALL, at that edge, set ptr=0, timer=dur[0], drv=pat[0] and state=RUN.
- drv shows the new pattern one cycle after start is sampled.
REQ-006 In RUN with timer!=0, the block SHALL decrement timer and hold drv and ptr.
- Each entry is therefore held for dur+1 cycles.
REQ-007 In RUN with timer==0 and ptr<len-1, the block SHALL set ptr=ptr+1, timer=dur[ptr+1] and drv=pat[ptr+1] at the same edge.
- There is no gap cycle between entries.
REQ-008 In RUN with timer==0, ptr==len-1 and loop=1, the block SHALL set ptr=0, timer=dur[0] and drv=pat[0].
REQ-009 In RUN with timer==0, ptr==len-1 and loop=0, the block SHALL go to IDLE, set drv=0, and pulse done for exactly one cycle.
REQ-010 A start with len==0 SHALL be ignored: no state change and no done pulse.
REQ-011 stop SHALL force IDLE and drv=0 at the next edge, with no done pulse.
- stop wins over a simultaneous start.
REQ-012 A write to the entry currently executing SHALL NOT alter its running timer or drv; the new value takes effect the next time that entry is loaded.
REQ-013 A change of len or loop during RUN SHALL take effect at the next end-of-entry decision.
- If ptr>=len at that decision, the block treats it as the last entry.
REQ-014 busy SHALL equal (state==RUN).
REQ-015 dur=0 SHALL give a 1-cycle entry; dur=2^TW-1 SHALL hold for 2^TW cycles without wrap of timer.

Reset
REQ-016 rst high SHALL asynchronously set:
- state=IDLE, ptr=0, timer=0, drv=0, done=0, busy=0.
- the retrigger counter and its edge register to 0.
REQ-017 rst SHALL NOT clear the table contents; table content after power-up is undefined unless written.
REQ-018 rst asserted mid-sequence SHALL abort it with no done pulse.

Configuration
REQ-019 Macro PULSAR_SEQ_RETRIG_EN defined SHALL compile in a free-running PW-bit counter.
- A rising edge of the counter MSB (detected with a one-cycle-delayed copy) acts as an internal start, ORed with the start port.
- This gives a retrigger every 2^PW cycles.
REQ-020 Macro PULSAR_SEQ_RETRIG_EN undefined SHALL remove the counter entirely; only the start port starts sequences.

Verification
REQ-021 Write entries 0..2 = {dur 2, pat 0x1}, {dur 0, pat 0x2}, {dur 4, pat 0x4}; set len=3, loop=0; pulse start.
- Required: drv = 0x1 for 3 cycles, 0x2 for 1 cycle, 0x4 for 5 cycles, then 0.
- Required: done is high in the cycle drv returns to 0; busy is high for exactly 9 cycles.
REQ-022 Repeat REQ-021 with loop=1.
- Required: drv pattern period is 9 cycles, repeating; done is never asserted.
REQ-023 Pulse start and stop in the same cycle while in RUN.
- Required: IDLE and drv=0 at the next edge; no done pulse.
REQ-024 With len=0, pulse start.
- Required: busy stays 0 and drv stays 0.
REQ-025 With PULSAR_SEQ_RETRIG_EN defined, PW=6, len=1, entry 0 = {dur 3, pat 0xF}.
- Required: drv=0xF for 4 cycles starting every 64 cycles.
- Without the macro: no activity occurs without the start port.
REQ-026 Assert rst mid-entry (timer=3).
- Required: drv=0 and busy=0 immediately, with no clock edge needed.
- Required: table contents are still readable and unchanged after rst releases.
